deskew_buffer: RTL and testbench

Output-side counterpart of the systolic array's input skew stage. The array emits result lanes staggered in time: lane k of a wavefront arrives k enabled cycles after lane 0. This block re-aligns each wavefront into one N-lane word, tags it valid, and queues it in a small first-word-fall-through FIFO. The FIFO gives downstream logic a valid/ready interface without stalling the array.

---
 rtl/deskew_if.sv | 30 +++
 rtl/deskew_buffer.sv | 138 +++++++++++++
 tb/tb_deskew_buffer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/deskew_if.sv
// deskew_if: handshake/bus bundle for deskew_buffer.
//   master : drives enable, in_valid, skewed_input, out_ready; observes outputs
//   slave  : the deskew buffer; drives out_valid, aligned_output, count, overflow
interface deskew_if #(
  parameter int unsigned N          = 4,
  parameter int unsigned D_W        = 8,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned W     = N * D_W;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic             enable;
  logic             in_valid;
  logic [W-1:0]     skewed_input;
  logic             out_ready;
  logic             out_valid;
  logic [W-1:0]     aligned_output;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output enable, in_valid, skewed_input, out_ready,
    input  out_valid, aligned_output, count, overflow
  );

  modport slave (
    input  enable, in_valid, skewed_input, out_ready,
    output out_valid, aligned_output, count, overflow
  );
endinterface

// File: rtl/deskew_buffer.sv
// deskew_buffer: re-aligns staggered systolic-array result lanes into one
// N-lane word per wavefront and queues it in a first-word-fall-through FIFO.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : deskew_if.slave (enable, in_valid, skewed_input, out_ready in;
//           out_valid, aligned_output, count, overflow out)
module deskew_buffer #(
  parameter int unsigned N          = 4,
  parameter int unsigned D_W        = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  deskew_if.slave   bus
);
  localparam int unsigned W     = N * D_W;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  logic [W-1:0] push_word_c;
  logic         tag_out_c;

  // Lane N-1 needs no delay; it is the last lane of the wavefront to arrive.
  assign push_word_c[(N-1)*D_W +: D_W] = bus.skewed_input[(N-1)*D_W +: D_W];

  // Per-lane delay chains: lane k waits N-1-k enabled cycles.
  for (genvar k = 0; k < int'(N) - 1; k++) begin : g_lane
    localparam int unsigned L = N - 1 - k;
    logic [D_W-1:0] dly_q [L];
    logic [D_W-1:0] dly_d [L];

    always_comb begin
      for (int i = 0; i < int'(L); i++) dly_d[i] = dly_q[i];
      if (bus.enable) begin
        dly_d[0] = bus.skewed_input[k*D_W +: D_W];
        for (int i = 1; i < int'(L); i++) dly_d[i] = dly_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) dly_q <= '{default: '0};
      else       dly_q <= dly_d;
    end

    assign push_word_c[k*D_W +: D_W] = dly_q[L-1];
  end

  // Wavefront tag follows lane 0 through an N-1 stage chain.
  if (N > 1) begin : g_tag
    localparam int unsigned TAG_W = N - 1;
    logic [TAG_W-1:0] tag_q;
    logic [TAG_W-1:0] tag_d;

    always_comb begin
      tag_d = tag_q;
      if (bus.enable) tag_d = TAG_W'({tag_q, bus.in_valid});
    end

    always_ff @(posedge clk) begin
      if (reset) tag_q <= '0;
      else       tag_q <= tag_d;
    end

    assign tag_out_c = tag_q[TAG_W-1];
  end else begin : g_notag
    assign tag_out_c = bus.in_valid;
  end

  // Output FIFO state.
  logic [W-1:0]     mem_q [FIFO_DEPTH];
  logic [W-1:0]     mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     head_q, head_d;
  logic             overflow_q, overflow_d;
  logic             push_c, pop_c, push_acc_c, full_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Push/pop decision; a pop frees a slot for a push on the same edge.
  always_comb begin
    push_c     = bus.enable & tag_out_c;
    pop_c      = out_valid_q & bus.out_ready;
    full_c     = (count_q == FULL_CNT);
    push_acc_c = push_c & (~full_c | pop_c);

    for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_d[i] = mem_q[i];
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q | (push_c & full_c & ~pop_c);

    if (push_acc_c) begin
      mem_d[wr_ptr_q] = push_word_c;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_c) rd_ptr_d = ptr_inc(rd_ptr_q);

    count_d     = count_q + CNT_W'(push_acc_c) - CNT_W'(pop_c);
    out_valid_d = (count_d != '0);

    // Registered head: the new word becomes head only if it lands at the read slot.
    if (count_d == '0)                                 head_d = '0;
    else if (push_acc_c && (rd_ptr_d == wr_ptr_q))     head_d = push_word_c;
    else                                               head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q       <= '{default: '0};
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      head_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      head_q      <= head_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.aligned_output = head_q;
  assign bus.count          = count_q;
  assign bus.overflow       = overflow_q;
endmodule

// File: tb/tb_deskew_buffer.sv
// tb_deskew_buffer: self-checking bench for deskew_buffer. Vector table,
// directed multi-cycle sequences and random traffic, all compared against a
// queue-based reference model built from the wavefront arrival rules.
module tb_deskew_buffer;
  localparam int unsigned N     = 4;
  localparam int unsigned D_W   = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = N * D_W;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  deskew_if #(.N(N), .D_W(D_W), .FIFO_DEPTH(DEPTH)) bus ();

  deskew_buffer #(.N(N), .D_W(D_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: last N-1 enabled input records plus a word queue.
  logic [W-1:0] m_fifo [$];
  logic         m_ovf;
  logic [W-1:0] h_data [$];
  logic         h_tag  [$];

  task automatic model_reset();
    m_fifo.delete();
    h_data.delete();
    h_tag.delete();
    for (int i = 0; i < int'(N) - 1; i++) begin
      h_data.push_back('0);
      h_tag.push_back(1'b0);
    end
    m_ovf = 1'b0;
  endtask

  task automatic model_step(input logic rst, input logic en, input logic iv,
                            input logic [W-1:0] data, input logic rdy);
    logic         pop;
    logic         push;
    logic [W-1:0] word;
    logic [W-1:0] rd [$];
    logic         rt [$];
    if (rst) begin
      model_reset();
      return;
    end
    pop  = (m_fifo.size() != 0) && rdy;
    push = 1'b0;
    word = '0;
    if (en) begin
      // Record j is the input from the enabled edge N-1-j edges ago.
      rd = h_data; rd.push_back(data);
      rt = h_tag;  rt.push_back(iv);
      push = rt[0];
      for (int k = 0; k < int'(N); k++) begin
        logic [W-1:0] r;
        r = rd[k];
        word[k*D_W +: D_W] = r[k*D_W +: D_W];
      end
      void'(rd.pop_front());
      void'(rt.pop_front());
      h_data = rd;
      h_tag  = rt;
    end
    if (push && m_fifo.size() == DEPTH && !pop) m_ovf = 1'b1;
    if (pop) void'(m_fifo.pop_front());
    if (push && !(m_ovf && m_fifo.size() == DEPTH && !pop)) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(word);
    end
  endtask

  // One clock: drive at negedge, clock, compare against model 1 time unit later.
  task automatic cycle(input logic rst, input logic en, input logic iv,
                       input logic [W-1:0] data, input logic rdy);
    @(negedge clk);
    reset            = rst;
    bus.enable       = en;
    bus.in_valid     = iv;
    bus.skewed_input = data;
    bus.out_ready    = rdy;
    model_step(rst, en, iv, data, rdy);
    @(posedge clk);
    #1;
    chk("model_out_valid", 64'(bus.out_valid), 64'(m_fifo.size() != 0));
    chk("model_count", 64'(bus.count), 64'(m_fifo.size()));
    chk("model_aligned_output", 64'(bus.aligned_output),
        64'((m_fifo.size() != 0) ? m_fifo[0] : '0));
    chk("model_overflow", 64'(bus.overflow), 64'(m_ovf));
  endtask

  // Wavefront w carries lane k = 16*w+k; lane k of w arrives in cycle w+k.
  function automatic logic [W-1:0] wave_in(input int c, input int nw);
    logic [W-1:0] d;
    d = '0;
    for (int k = 0; k < int'(N); k++) begin
      int w;
      w = c - k;
      if (w >= 0 && w < nw) d[k*D_W +: D_W] = D_W'(16 * w + k);
    end
    return d;
  endfunction

  function automatic logic [W-1:0] wave_word(input int w);
    logic [W-1:0] d;
    for (int k = 0; k < int'(N); k++) d[k*D_W +: D_W] = D_W'(16 * w + k);
    return d;
  endfunction

  typedef struct {
    logic             rst, en, iv;
    logic [W-1:0]     data;
    logic             rdy;
    logic             exp_valid;
    logic [W-1:0]     exp_out;
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs [$];

  task automatic add_vec(input logic rst, input logic en, input logic iv, input logic [W-1:0] data,
                         input logic rdy, input logic ev, input logic [W-1:0] eo,
                         input int ec, input logic eovf);
    vec_t v;
    v.rst = rst; v.en = en; v.iv = iv; v.data = data; v.rdy = rdy;
    v.exp_valid = ev; v.exp_out = eo; v.exp_cnt = CNT_W'(ec); v.exp_ovf = eovf;
    vecs.push_back(v);
  endtask

  initial begin
    reset            = 1'b1;
    bus.enable       = 1'b0;
    bus.in_valid     = 1'b0;
    bus.skewed_input = '0;
    bus.out_ready    = 1'b0;
    model_reset();

    // Single wavefront, then the same wavefront with an enable gap in cycle 2.
    add_vec(1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 0);
    add_vec(0, 1, 1, 32'h00000011, 1, 0, 32'h0,        0, 0);
    add_vec(0, 1, 0, 32'h00002200, 1, 0, 32'h0,        0, 0);
    add_vec(0, 1, 0, 32'h00330000, 1, 0, 32'h0,        0, 0);
    add_vec(0, 1, 0, 32'h44000000, 1, 1, 32'h44332211, 1, 0);
    add_vec(0, 1, 0, 32'h00000000, 1, 0, 32'h0,        0, 0);
    add_vec(0, 1, 0, 32'h00000000, 1, 0, 32'h0,        0, 0);
    add_vec(1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 0);
    add_vec(0, 1, 1, 32'h00000011, 1, 0, 32'h0,        0, 0);
    add_vec(0, 1, 0, 32'h00002200, 1, 0, 32'h0,        0, 0);
    add_vec(0, 0, 1, 32'hdeadbeef, 1, 0, 32'h0,        0, 0);
    add_vec(0, 1, 0, 32'h00330000, 1, 0, 32'h0,        0, 0);
    add_vec(0, 1, 0, 32'h44000000, 1, 1, 32'h44332211, 1, 0);
    add_vec(0, 1, 0, 32'h00000000, 1, 0, 32'h0,        0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].en, vecs[i].iv, vecs[i].data, vecs[i].rdy);
      chk("vec_out_valid", 64'(bus.out_valid), 64'(vecs[i].exp_valid));
      chk("vec_aligned_output", 64'(bus.aligned_output), 64'(vecs[i].exp_out));
      chk("vec_count", 64'(bus.count), 64'(vecs[i].exp_cnt));
      chk("vec_overflow", 64'(bus.overflow), 64'(vecs[i].exp_ovf));
    end

    // Streaming: 6 back-to-back wavefronts, one word per cycle from cycle 4.
    cycle(1, 0, 0, '0, 1);
    for (int c = 0; c < 12; c++) begin
      cycle(0, 1, c < 6, wave_in(c, 6), 1);
      if (c + 1 >= 4 && c + 1 < 10) begin
        chk("stream_valid", 64'(bus.out_valid), 64'(1));
        chk("stream_word", 64'(bus.aligned_output), 64'(wave_word(c + 1 - 4)));
      end else begin
        chk("stream_idle", 64'(bus.out_valid), 64'(0));
      end
      chk("stream_count_le1", 64'(bus.count <= 1), 64'(1));
      chk("stream_overflow", 64'(bus.overflow), 64'(0));
    end

    // Backpressure: 5 pushes into a 4-deep FIFO with no pops.
    cycle(1, 0, 0, '0, 0);
    for (int c = 0; c < 8; c++) begin
      cycle(0, 1, c < 5, wave_in(c, 5), 0);
      if (c == 6) begin
        chk("bp_full_count", 64'(bus.count), 64'(4));
        chk("bp_no_ovf_yet", 64'(bus.overflow), 64'(0));
      end
    end
    chk("bp_count_after_5", 64'(bus.count), 64'(4));
    chk("bp_overflow", 64'(bus.overflow), 64'(1));
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain_valid", 64'(bus.out_valid), 64'(1));
      chk("bp_drain_word", 64'(bus.aligned_output), 64'(wave_word(i)));
      cycle(0, 1, 0, '0, 1);
    end
    for (int i = 0; i < 3; i++) begin
      chk("bp_fifth_absent", 64'(bus.out_valid), 64'(0));
      chk("bp_overflow_sticky", 64'(bus.overflow), 64'(1));
      cycle(0, 1, 0, '0, 1);
    end
    cycle(1, 0, 0, '0, 0);
    chk("bp_overflow_cleared", 64'(bus.overflow), 64'(0));

    // Push and pop on the same edge while full.
    for (int c = 0; c < 8; c++) cycle(0, 1, c < 5, wave_in(c, 5), c == 7);
    chk("fullpp_count", 64'(bus.count), 64'(4));
    chk("fullpp_overflow", 64'(bus.overflow), 64'(0));
    for (int i = 1; i < 5; i++) begin
      chk("fullpp_drain_word", 64'(bus.aligned_output), 64'(wave_word(i)));
      cycle(0, 1, 0, '0, 1);
    end
    chk("fullpp_empty", 64'(bus.out_valid), 64'(0));

    // Reset with two words queued and a wavefront in flight.
    cycle(1, 0, 0, '0, 0);
    for (int c = 0; c < 5; c++) cycle(0, 1, c == 0 || c == 1 || c == 3, W'($urandom), 0);
    chk("rst_mid_queued", 64'(bus.count), 64'(2));
    cycle(1, 1, 0, W'($urandom), 0);
    chk("rst_mid_count", 64'(bus.count), 64'(0));
    chk("rst_mid_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_mid_data", 64'(bus.aligned_output), 64'(0));
    for (int c = 0; c < 8; c++) begin
      cycle(0, 1, 0, W'($urandom), 1);
      chk("rst_mid_no_word", 64'(bus.out_valid), 64'(0));
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 8,
            $urandom_range(0, 2) == 0, W'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
